// File: rtl/escalonador_asteroides_pkg.sv
// Shared game constants: slot count, datapath timeout and scheduler state encodings.
// No logic; constants only.
// Not applicable: no flow control lives here.
package escalonador_asteroides_pkg;

    localparam int NUM_AST_DEF = 4;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ESPERA   = 4'd1,
        ST_BUSCA    = 4'd2,
        ST_CARREGA  = 4'd3,
        ST_PROCESSA = 4'd4,
        ST_AVALIA   = 4'd5,
        ST_GRAVA    = 4'd6,
        ST_FIM      = 4'd7
    } estado_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/escalonador_asteroides_prox_slot.sv
// Slot search step: tests one slot of the snapshot mask and yields the wrapped next index.
// Latency: purely combinational, one slot examined per evaluation.
// Backpressure: none; the caller advances start/visitados when it accepts a result.
module prox_slot #(
    parameter int NUM_AST = 4,
    parameter int IDX_W   = 2,
    parameter int VIS_W   = 3
) (
    input  logic [NUM_AST-1:0] mask,
    input  logic [IDX_W-1:0]   start,
    input  logic [VIS_W-1:0]   visitados,
    output logic [IDX_W-1:0]   next_idx,
    output logic               found,
    output logic               fim_busca
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_AST - 1);
    localparam logic [VIS_W-1:0] VIS_ALL  = VIS_W'(NUM_AST);
    localparam logic [VIS_W-1:0] VIS_LAST = VIS_W'(NUM_AST - 1);

    logic esgotado;
    logic bit_ativo;

    always_comb begin
        esgotado  = (visitados == VIS_ALL);
        bit_ativo = mask[start];
        found     = !esgotado && bit_ativo;
        // A miss on the final unvisited slot ends the round in the same cycle.
        fim_busca = esgotado || (!bit_ativo && (visitados == VIS_LAST));
        next_idx  = (start == IDX_LAST) ? '0 : start + 1'b1;
    end

endmodule

// File: rtl/escalonador_asteroides.sv
// Round-robin scheduler sharing one movement/collision datapath across asteroid slots.
// Latency: one slot examined per cycle; each served slot costs load, wait, evaluate and optional store.
// Backpressure: waits on dp_done up to TIMEOUT cycles; ticks during a busy round queue once, then flag overrun.
module escalonador_asteroides
    import escalonador_asteroides_pkg::*;
#(
    parameter int NUM_AST = NUM_AST_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int IDX_W   = idx_width(NUM_AST)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               tick,
    input  logic [NUM_AST-1:0] ativo,
    input  logic               dp_done,
    input  logic               dp_colisao,
    input  logic               dp_acertou,
    output logic [IDX_W-1:0]   dp_slot,
    output logic               dp_load,
    output logic               dp_start,
    output logic               dp_store,
    output logic [NUM_AST-1:0] clear_slot,
    output logic               perde_vida,
    output logic               rodada_fim,
    output logic               erro_timeout,
    output logic               overrun,
    output logic               ocupado,
    output logic [3:0]         db_estado
);

    localparam int VIS_W = $clog2(NUM_AST + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_AST - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    estado_t             estado, prox_estado;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_prox;
    logic [VIS_W-1:0]    visitados;
    logic [NUM_AST-1:0]  mask_r;
    logic [CNT_W-1:0]    cnt_espera;
    logic                pending;
    logic                colisao_r;
    logic                acertou_r;
    logic                erro_timeout_r;
    logic                overrun_r;
    logic                slot_found;
    logic                busca_fim;
    logic                inicia_rodada;
    logic                estourou;
    logic                descarta;

    prox_slot #(
        .NUM_AST (NUM_AST),
        .IDX_W   (IDX_W),
        .VIS_W   (VIS_W)
    ) u_prox_slot (
        .mask      (mask_r),
        .start     (idx),
        .visitados (visitados),
        .next_idx  (idx_prox),
        .found     (slot_found),
        .fim_busca (busca_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= ST_IDLE;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado   = estado;
        inicia_rodada = 1'b0;
        estourou      = 1'b0;
        descarta      = 1'b0;
        dp_load       = 1'b0;
        dp_start      = 1'b0;
        dp_store      = 1'b0;
        clear_slot    = '0;
        perde_vida    = 1'b0;
        rodada_fim    = 1'b0;
        ocupado       = 1'b1;
        db_estado     = estado;
        case (estado)
            ST_IDLE: begin
                ocupado = 1'b0;
                if (iniciar) prox_estado = ST_ESPERA;
            end
            ST_ESPERA: begin
                ocupado = 1'b0;
                if (tick || pending) begin
                    inicia_rodada = 1'b1;
                    prox_estado   = ST_BUSCA;
                end
            end
            ST_BUSCA: begin
                if (slot_found)     prox_estado = ST_CARREGA;
                else if (busca_fim) prox_estado = ST_FIM;
            end
            ST_CARREGA: begin
                dp_load     = 1'b1;
                prox_estado = ST_PROCESSA;
            end
            ST_PROCESSA: begin
                dp_start = 1'b1;
                if (dp_done) begin
                    prox_estado = ST_AVALIA;
                end else if (cnt_espera == CNT_LAST) begin
                    estourou    = 1'b1;
                    prox_estado = ST_BUSCA;
                end
            end
            ST_AVALIA: begin
                // A hit destroys the asteroid before it can reach the ship.
                descarta = acertou_r || colisao_r;
                if (descarta) begin
                    clear_slot[idx] = 1'b1;
                    perde_vida      = colisao_r && !acertou_r;
                    prox_estado     = ST_BUSCA;
                end else begin
                    prox_estado     = ST_GRAVA;
                end
            end
            ST_GRAVA: begin
                dp_store    = 1'b1;
                prox_estado = ST_BUSCA;
            end
            ST_FIM: begin
                rodada_fim  = 1'b1;
                prox_estado = ST_ESPERA;
            end
            default: prox_estado = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr            <= '0;
            idx            <= '0;
            visitados      <= '0;
            mask_r         <= '0;
            cnt_espera     <= '0;
            colisao_r      <= 1'b0;
            acertou_r      <= 1'b0;
            erro_timeout_r <= 1'b0;
        end else begin
            erro_timeout_r <= estourou;
            case (estado)
                ST_ESPERA: begin
                    if (inicia_rodada) begin
                        mask_r    <= ativo;
                        idx       <= ptr;
                        visitados <= '0;
                    end
                end
                ST_BUSCA: begin
                    if (slot_found) begin
                        visitados <= visitados + 1'b1;
                    end else if (!busca_fim) begin
                        visitados <= visitados + 1'b1;
                        idx       <= idx_prox;
                    end
                end
                ST_CARREGA: cnt_espera <= '0;
                ST_PROCESSA: begin
                    if (dp_done) begin
                        colisao_r <= dp_colisao;
                        acertou_r <= dp_acertou;
                    end else if (estourou) begin
                        idx <= idx_prox;
                    end else begin
                        cnt_espera <= cnt_espera + 1'b1;
                    end
                end
                ST_AVALIA: if (descarta) idx <= idx_prox;
                ST_GRAVA:  idx <= idx_prox;
                ST_FIM:    ptr <= (ptr == IDX_LAST) ? '0 : ptr + 1'b1;
                default: ;
            endcase
        end
    end

    // One tick may wait behind a busy round; a second one is lost and latched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (inicia_rodada) begin
            pending <= 1'b0;
        end else if (tick && ocupado) begin
            if (pending) overrun_r <= 1'b1;
            else         pending   <= 1'b1;
        end
    end

    assign dp_slot      = idx;
    assign erro_timeout = erro_timeout_r;
    assign overrun      = overrun_r;

endmodule
